// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: fetch FSM states, fault codes, NOP encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- the canonical RISC-V NOP, also used by decode for bubbles.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds pc, pc+4 and the instruction word toward decode.
// Priority is reset, then flush (drop contents), then load, otherwise hold.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr
);

  // Register update; an empty slot always presents a NOP so decode never sees stale data.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid    <= 1'b0;
      pc       <= '0;
      pc_plus4 <= '0;
      instr    <= NOP_INSTR;
    end else if (load) begin
      valid    <= 1'b1;
      pc       <= in_pc;
      pc_plus4 <= in_pc + 32'd4;
      instr    <= in_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory, and feeds
// the IF/ID register. Redirects flush the slot; misaligned targets and
// out-of-range PCs halt the stage until reset.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              MEM_WORDS = 1024,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [XLEN-1:0] out_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            halted,
  output logic [1:0]      fault_code
  ,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t    state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [1:0]      fault_reg;
  logic [XLEN-1:0] count_reg;

  logic advance;
  logic transfer;
  logic pc_in_range;
  logic load;
  logic flush;

  assign advance     = !out_valid || out_ready;
  assign transfer    = out_valid && out_ready;
  // Word index compared unsigned at full width so large MEM_WORDS cannot truncate.
  assign pc_in_range = ({2'b00, pc_reg[XLEN-1:2]} < MEM_WORDS);

  assign imem_addr   = pc_reg;
  assign halted      = (state_reg == FS_HALT);
  assign fault_code  = fault_reg;
  assign fetch_count = count_reg;

  // IF/ID slot control: redirect and halt empty it, a range fault empties it instead of capturing.
  always_comb begin
    load  = 1'b0;
    flush = 1'b0;
    if (state_reg == FS_HALT) begin
      flush = 1'b1;
    end else if (redirect_valid) begin
      flush = 1'b1;
    end else if (advance) begin
      if (pc_in_range) begin
        load = 1'b1;
      end else begin
        flush = 1'b1;
      end
    end
  end

  // FSM, PC, sticky fault and accepted-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FS_RUN;
      pc_reg    <= RESET_PC;
      fault_reg <= FAULT_NONE;
      count_reg <= '0;
    end else begin
      case (state_reg)
        FS_RUN: begin
          if (redirect_valid) begin
            // The held instruction is discarded, so a coincident transfer is not counted.
            if (redirect_target[1:0] != 2'b00) begin
              state_reg <= FS_HALT;
              fault_reg <= FAULT_MISALIGN;
            end else begin
              pc_reg <= redirect_target;
            end
          end else begin
            if (transfer) begin
              count_reg <= count_reg + 32'd1;
            end
            if (advance) begin
              if (pc_in_range) begin
                pc_reg <= pc_reg + 32'd4;
              end else begin
                state_reg <= FS_HALT;
                fault_reg <= FAULT_RANGE;
              end
            end
          end
        end
        default: begin
          // HALT: everything frozen until reset.
          state_reg <= FS_HALT;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .flush    (flush),
    .in_pc    (pc_reg),
    .in_instr (imem_rdata),
    .valid    (out_valid),
    .pc       (out_pc),
    .pc_plus4 (out_pc_plus4),
    .instr    (out_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard of expected {pc, instr} pairs is
// popped on each handshake, plus point checks for stall, redirect, faults, reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, 1024-word memory.
  logic        rst, out_ready, redirect_valid;
  logic [31:0] redirect_target, imem_addr, imem_rdata;
  logic        out_valid, halted;
  logic [31:0] out_pc, out_pc_plus4, out_instr, fetch_count;
  logic [1:0]  fault_code;

  // Small instance, 4-word memory, for the range fault.
  logic        s_rst, s_out_ready, s_redirect_valid;
  logic [31:0] s_redirect_target, s_imem_addr, s_imem_rdata;
  logic        s_out_valid, s_halted;
  logic [31:0] s_out_pc, s_out_pc_plus4, s_out_instr, s_fetch_count;
  logic [1:0]  s_fault_code;

  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] sb[$];

  // Instruction memory model: a distinct word per address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  assign imem_rdata   = instr_of(imem_addr);
  assign s_imem_rdata = instr_of(s_imem_addr);

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(1024), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halted(halted), .fault_code(fault_code), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(4), .NOP_INSTR(NOP)) dut_small (
    .clk(clk), .rst(s_rst), .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pc(s_out_pc),
    .out_pc_plus4(s_out_pc_plus4), .out_instr(s_out_instr),
    .redirect_valid(s_redirect_valid), .redirect_target(s_redirect_target),
    .halted(s_halted), .fault_code(s_fault_code), .fetch_count(s_fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    sb.push_back({pc, instr_of(pc)});
  endtask

  // Scoreboard: every counted handshake on the main instance must match the next expected fetch.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_underflow: observed pc %h expected no transfer", out_pc);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("sb_pc", out_pc, e[63:32]);
        check("sb_pc4", out_pc_plus4, e[63:32] + 32'd4);
        check("sb_instr", out_instr, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    s_rst = 1'b1; s_out_ready = 1'b1; s_redirect_valid = 1'b0; s_redirect_target = '0;

    // Reset state.
    step(); step();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", out_instr, NOP);
    check("rst_pc", out_pc, 32'd0);
    check("rst_pc4", out_pc_plus4, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_fault", {30'b0, fault_code}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    rst = 1'b0;

    // Sequential run, one cycle latency.
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    step();
    check("run_valid0", {31'b0, out_valid}, 32'd1);
    check("run_pc0", out_pc, 32'h0);
    check("run_instr0", out_instr, instr_of(32'h0));
    step();
    check("run_pc4", out_pc, 32'h4);
    step();
    check("run_pc8", out_pc, 32'h8);
    out_ready = 1'b0;

    // Stall three cycles at pc 8.
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_pc", out_pc, 32'h8);
      check("stall_instr", out_instr, instr_of(32'h8));
      check("stall_addr", imem_addr, 32'hC);
      check("stall_count", fetch_count, 32'd2);
    end
    out_ready = 1'b1;
    step();
    check("release_pc", out_pc, 32'hC);
    step();
    check("run_pc16", out_pc, 32'h10);
    check("run_count4", fetch_count, 32'd4);

    // Redirect during stall; held pc 16 is discarded.
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", {31'b0, out_valid}, 32'd0);
    check("redir_instr", out_instr, NOP);
    check("redir_count", fetch_count, 32'd4);
    push(32'h40);
    step();
    check("redir_pc40", out_pc, 32'h40);
    out_ready = 1'b1;
    step();
    check("post_pc44", out_pc, 32'h44);
    check("post_count", fetch_count, 32'd5);

    // Redirect coinciding with a transfer: transfer not counted.
    redirect_valid = 1'b1; redirect_target = 32'h80;
    step();
    redirect_valid = 1'b0;
    check("coin_valid", {31'b0, out_valid}, 32'd0);
    check("coin_count", fetch_count, 32'd5);
    step();
    check("coin_pc80", out_pc, 32'h80);

    // Misaligned redirect halts with fault 1; later redirects ignored.
    redirect_valid = 1'b1; redirect_target = 32'h42;
    step();
    check("mis_halted", {31'b0, halted}, 32'd1);
    check("mis_fault", {30'b0, fault_code}, 32'd1);
    check("mis_valid", {31'b0, out_valid}, 32'd0);
    check("mis_addr", imem_addr, 32'h84);
    redirect_target = 32'h80;
    step(); step();
    redirect_valid = 1'b0;
    check("halt_halted", {31'b0, halted}, 32'd1);
    check("halt_fault", {30'b0, fault_code}, 32'd1);
    check("halt_addr", imem_addr, 32'h84);
    check("halt_valid", {31'b0, out_valid}, 32'd0);
    check("halt_count", fetch_count, 32'd5);

    // Reset mid-stream with a redirect pending.
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b0;
    step();
    check("mid_valid_pre", {31'b0, out_valid}, 32'd1);
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    check("mid_valid", {31'b0, out_valid}, 32'd0);
    check("mid_addr", imem_addr, 32'h0);
    check("mid_fault", {30'b0, fault_code}, 32'd0);
    check("mid_halted", {31'b0, halted}, 32'd0);
    check("mid_count", fetch_count, 32'd0);
    rst = 1'b0; redirect_valid = 1'b0;

    // Out-of-range on the 4-word instance.
    s_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rng_valid", {31'b0, s_out_valid}, 32'd1);
      check("rng_pc", s_out_pc, 32'(i * 4));
      check("rng_instr", s_out_instr, instr_of(32'(i * 4)));
    end
    step();
    check("rng_halted", {31'b0, s_halted}, 32'd1);
    check("rng_fault", {30'b0, s_fault_code}, 32'd2);
    check("rng_addr", s_imem_addr, 32'h10);
    check("rng_valid_off", {31'b0, s_out_valid}, 32'd0);
    check("rng_count", s_fetch_count, 32'd4);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the memory.
- Captures the returned instruction into a registered IF/ID output with a valid/ready handshake toward decode.
- Handles stall back-pressure, branch/jump redirects, and fetch faults that halt the stage until reset.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- MEM_WORDS, 1024: number of 32-bit words in instruction memory; PCs whose word index is >= MEM_WORDS fault.
- NOP_INSTR, 32'h0000_0013: value driven on out_instr whenever out_valid=0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals pc, combinational from the PC register.
- imem_rdata  in  32  instruction word; combinational read of imem_addr, same cycle.
- out_valid  out  1  IF/ID register holds a valid instruction.
- out_ready  in  1  decode accepts out_* this cycle.
- out_pc  out  32  PC of out_instr.
- out_pc_plus4  out  32  out_pc+4, modulo 2^32.
- out_instr  out  32  fetched instruction word.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_target  in  32  new PC, valid with redirect_valid.
- halted  out  1  stage is in HALT.
- fault_code  out  2  0 none, 1 misaligned target, 2 out-of-range PC; sticky until reset.
- fetch_count  out  32  number of instructions accepted by decode; wraps at 2^32.

Behaviour:
- States: RUN and HALT. HALT is exited only by rst.
- Reset (rst=1 at a clock edge):
  - state=RUN, pc=RESET_PC, out_valid=0, out_pc=0, out_pc_plus4=0, out_instr=NOP_INSTR.
  - fault_code=0, halted=0, fetch_count=0.
  - rst overrides every other input in that cycle.
- advance = !out_valid || out_ready.
- RUN, no redirect, advance=1, pc in range:
  - IF/ID <= {pc, pc+4, imem_rdata}; out_valid<=1; pc<=pc+4.
  - Latency is one cycle from PC to out_*. Sustained throughput is one instruction per cycle while out_ready=1.
- RUN, advance=0 (stall): pc and the IF/ID register hold; out_* stay stable while out_valid=1 && out_ready=0.
- Handshake:
  - A transfer occurs on a cycle with out_valid && out_ready; fetch_count increments by 1 on each transfer.
  - out_valid never drops without a transfer, except on redirect, fault, or reset.
- Redirect (RUN, redirect_valid=1): highest priority after rst, independent of advance.
  - Next cycle: out_valid=0 and out_instr=NOP_INSTR; the currently held instruction is discarded and not counted, even if out_ready=1 that cycle.
  - If redirect_target[1:0]!=0: state<=HALT, fault_code<=1, pc unchanged.
  - Otherwise: pc<=redirect_target; the first fetch from the target happens the cycle after.
- Out-of-range PC:
  - In RUN with advance=1 and pc[31:2]>=MEM_WORDS, there is no capture.
  - state<=HALT, fault_code<=2, out_valid<=0.
- HALT:
  - halted=1, out_valid=0, pc frozen, redirect_valid ignored.
  - fault_code and fetch_count hold.
  - imem_addr keeps driving the frozen pc.
- PC arithmetic is 32-bit unsigned; pc+4 wraps from 32'hFFFF_FFFC to 0, then faults as out-of-range if applicable.
- Simultaneous redirect and transfer: the transfer is not counted; the redirect wins.

Decomposition:
- Shared package (riscv_pkg):
  - Fault-code constants FAULT_NONE/FAULT_MISALIGN/FAULT_RANGE.
  - State encoding FS_RUN/FS_HALT.
  - NOP_INSTR constant, shared with decode.
  - XLEN=32.
- One natural sub-module, if_id_reg: the handshaked output register holding pc, pc_plus4 and instr, with load/flush/hold controls.
- PC/next-PC logic and the FSM stay in fetch_unit.

Test Plan:
- Reset then run: rst=1 for 2 cycles, out_ready=1, memory words 0..3 = A,B,C,D.
  - Required: first out_valid 1 cycle after reset release with out_pc=0/out_instr=A.
  - Then 4/B, 8/C, 12/D on consecutive cycles; fetch_count=4.
- Stall: hold out_ready=0 for 3 cycles while out_pc=8.
  - Required: out_pc=8 and out_instr=C stable for all 3 cycles, imem_addr=12 held, fetch_count unchanged.
  - Releasing out_ready gives out_pc=12 next.
- Redirect during stall: out_valid=1, out_ready=0, redirect_target=0x40.
  - Required: out_valid=0 next cycle, then out_pc=0x40 the cycle after; discarded instruction not counted.
- Misaligned redirect: redirect_target=0x42.
  - Required: halted=1, fault_code=1, out_valid=0 next cycle.
  - Further redirects to 0x80 are ignored; only rst clears the fault.
- Out-of-range: MEM_WORDS=4, sequential run from 0.
  - Required: PCs 0,4,8,12 delivered, then halted=1 and fault_code=2 with pc=16; fetch_count=4.
- Reset mid-stream: assert rst while out_valid=1 and redirect_valid=1.
  - Required: next cycle out_valid=0, pc=RESET_PC, fault_code=0, fetch_count=0.
